// File: rtl/m2p_pkg.sv
// Shared types and constants for the method-to-pipe serializer.
package m2p_pkg;

  localparam int WORD_W       = 32;
  localparam int HDR_ID_W     = 16;
  localparam int HDR_PORTAL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  // Header beat: method index in the upper half, portal id in the lower half.
  function automatic logic [WORD_W-1:0] make_header(
    input logic [HDR_ID_W-1:0]     id,
    input logic [HDR_PORTAL_W-1:0] portal
  );
    return {id, portal};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request after ptr (with wrap) wins.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/m2p_serializer.sv
// Marshals N indication methods onto one 32-bit stream: header beat, then only the used payload words.
module m2p_serializer
  import m2p_pkg::*;
#(
  parameter int                       NUM_METHODS = 3,
  parameter int                       MAX_WORDS   = 4,
  parameter logic [NUM_METHODS*8-1:0] METHOD_LEN  = {8'd2, 8'd4, 8'd4},
  parameter logic [15:0]              PORTAL_ID   = 16'd5
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [NUM_METHODS-1:0]              method_ena,
  output logic [NUM_METHODS-1:0]              method_rdy,
  input  logic [NUM_METHODS*MAX_WORDS*WORD_W-1:0] method_data,
  output logic                                pipe_enq_ena,
  input  logic                                pipe_enq_rdy,
  output logic [WORD_W-1:0]                   pipe_enq_data,
  output logic                                pipe_enq_last
);

  localparam int IDX_W = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  logic [7:0] len_tab [NUM_METHODS];

  for (genvar i = 0; i < NUM_METHODS; i++) begin : g_len
    assign len_tab[i] = METHOD_LEN[i*8 +: 8];
    if (int'(METHOD_LEN[i*8 +: 8]) > MAX_WORDS) begin : g_bad_len
      $error("m2p_serializer: METHOD_LEN[%0d] exceeds MAX_WORDS", i);
    end
  end

  state_t                 state, state_n;
  logic [NUM_METHODS-1:0] hold_valid;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       word_cnt, cnt_n;
  logic [WORD_W-1:0]      hold [NUM_METHODS][MAX_WORDS];
  logic [WORD_W-1:0]      sh [MAX_WORDS];

  logic [NUM_METHODS-1:0] grant;
  logic [IDX_W-1:0]       gidx;
  logic                   gany;
  logic                   xfer, load, adv;
  logic                   ena_n, last_n;
  logic [WORD_W-1:0]      data_n;

  assign method_rdy = ~hold_valid;

  rr_arbiter #(
    .N     (NUM_METHODS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (hold_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Capture stage: per-method holding registers.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_METHODS; i++) begin
      for (int w = 0; w < MAX_WORDS; w++) begin
        if (method_ena[i]) hold[i][w] <= method_data[(i*MAX_WORDS+w)*WORD_W +: WORD_W];
      end
    end
  end

  // Output stage: shift register feeding payload beats in word order.
  always_ff @(posedge CLK) begin
    if (load) begin
      for (int w = 0; w < MAX_WORDS; w++) sh[w] <= hold[gidx][w];
    end else if (adv) begin
      for (int w = 0; w < MAX_WORDS - 1; w++) sh[w] <= sh[w+1];
    end
  end

  always_comb begin
    xfer    = pipe_enq_ena & pipe_enq_rdy;
    // A new message loads from idle, or on the final beat so the next header follows without a gap.
    load    = gany && ((state == IDLE) || (xfer && pipe_enq_last));
    state_n = state;
    ena_n   = pipe_enq_ena;
    data_n  = pipe_enq_data;
    last_n  = pipe_enq_last;
    cnt_n   = word_cnt;
    adv     = 1'b0;
    if (load) begin
      state_n = HEADER;
      ena_n   = 1'b1;
      data_n  = make_header(HDR_ID_W'(gidx), PORTAL_ID);
      last_n  = (len_tab[gidx] == 8'd0);
      cnt_n   = CNT_W'(len_tab[gidx]);
    end else if (xfer) begin
      if (pipe_enq_last) begin
        state_n = IDLE;
        ena_n   = 1'b0;
        last_n  = 1'b0;
      end else begin
        state_n = PAYLOAD;
        data_n  = sh[0];
        last_n  = (word_cnt == CNT_W'(1));
        cnt_n   = word_cnt - CNT_W'(1);
        adv     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state         <= IDLE;
      hold_valid    <= '0;
      rr_ptr        <= IDX_W'(NUM_METHODS - 1);
      word_cnt      <= '0;
      pipe_enq_ena  <= 1'b0;
      pipe_enq_data <= '0;
      pipe_enq_last <= 1'b0;
    end else begin
      state         <= state_n;
      word_cnt      <= cnt_n;
      pipe_enq_ena  <= ena_n;
      pipe_enq_data <= data_n;
      pipe_enq_last <= last_n;
      hold_valid    <= (hold_valid & ~(load ? grant : '0)) | method_ena;
      if (load) rr_ptr <= gidx;
    end
  end

endmodule

// File: tb/tb_m2p_serializer.sv
// Scoreboard bench for m2p_serializer: expected beats queued at stimulus time, popped per transfer.
module tb_m2p_serializer;

  localparam int NM = 3;
  localparam int MW = 4;

  logic              CLK  = 1'b0;
  logic              nRST = 1'b0;
  logic [NM-1:0]     method_ena, method_rdy, method_ena_z, method_rdy_z;
  logic [NM*MW*32-1:0] method_data, method_data_z;
  logic              pipe_enq_ena, pipe_enq_rdy, pipe_enq_last;
  logic [31:0]       pipe_enq_data;
  logic              pipe_enq_ena_z, pipe_enq_rdy_z, pipe_enq_last_z;
  logic [31:0]       pipe_enq_data_z;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int beats_z = 0;
  logic [32:0] sb[$];
  logic [32:0] sbz[$];
  int len_main[NM] = '{4, 4, 2};
  int len_z[NM]    = '{0, 2, 4};

  m2p_serializer #(
    .NUM_METHODS (NM),
    .MAX_WORDS   (MW),
    .METHOD_LEN  ({8'd2, 8'd4, 8'd4}),
    .PORTAL_ID   (16'd5)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .method_ena    (method_ena),
    .method_rdy    (method_rdy),
    .method_data   (method_data),
    .pipe_enq_ena  (pipe_enq_ena),
    .pipe_enq_rdy  (pipe_enq_rdy),
    .pipe_enq_data (pipe_enq_data),
    .pipe_enq_last (pipe_enq_last)
  );

  m2p_serializer #(
    .NUM_METHODS (NM),
    .MAX_WORDS   (MW),
    .METHOD_LEN  ({8'd4, 8'd2, 8'd0}),
    .PORTAL_ID   (16'd5)
  ) dut_z (
    .CLK           (CLK),
    .nRST          (nRST),
    .method_ena    (method_ena_z),
    .method_rdy    (method_rdy_z),
    .method_data   (method_data_z),
    .pipe_enq_ena  (pipe_enq_ena_z),
    .pipe_enq_rdy  (pipe_enq_rdy_z),
    .pipe_enq_data (pipe_enq_data_z),
    .pipe_enq_last (pipe_enq_last_z)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_args(input int ch, input logic [31:0] base, input bit z);
    for (int w = 0; w < MW; w++) begin
      if (z) method_data_z[(ch*MW+w)*32 +: 32] = base + w;
      else   method_data[(ch*MW+w)*32 +: 32]   = base + w;
    end
  endtask

  task automatic push_msg(input int ch, input logic [31:0] base, input bit z);
    int len;
    logic [32:0] b;
    len = z ? len_z[ch] : len_main[ch];
    b = {(len == 0), 16'(ch), 16'd5};
    if (z) sbz.push_back(b); else sb.push_back(b);
    for (int w = 0; w < len; w++) begin
      b = {(w == len - 1), base + w};
      if (z) sbz.push_back(b); else sb.push_back(b);
    end
  endtask

  task automatic drain(input bit rand_rdy, output int idle);
    bit started;
    started = 1'b0;
    idle    = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge CLK); #1;
      if (sb.size() == 0 && sbz.size() == 0) break;
      if (rand_rdy) pipe_enq_rdy = 1'($urandom_range(0, 1));
      if (pipe_enq_ena) started = 1'b1;
      else if (started) idle++;
    end
    pipe_enq_rdy = 1'b1;
    check("drain_empty", 64'(sb.size() + sbz.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    nRST = 1'b1;
    method_ena   = '0;
    method_ena_z = '0;
    sb.delete();
    sbz.delete();
    #1;
    check("rst_ena", pipe_enq_ena, 1'b0);
    @(posedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b0;
    check("rst_rdy", method_rdy, 3'b111);
  endtask

  always @(negedge CLK) begin : mon_main
    logic [32:0] cur;
    logic [32:0] held;
    bit          stalled;
    cur = {pipe_enq_last, pipe_enq_data};
    if (nRST) begin
      stalled = 1'b0;
    end else begin
      if (stalled && pipe_enq_ena) check("stall_hold", cur, held);
      stalled = pipe_enq_ena && !pipe_enq_rdy;
      held    = cur;
      if (pipe_enq_ena && pipe_enq_rdy) begin
        beats++;
        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
        else check("beat", cur, sb.pop_front());
      end
    end
  end

  always @(negedge CLK) begin : mon_z
    if (!nRST && pipe_enq_ena_z && pipe_enq_rdy_z) begin
      beats_z++;
      if (sbz.size() == 0) check("z_underflow", 64'(sbz.size()), 64'd1);
      else check("z_beat", {pipe_enq_last_z, pipe_enq_data_z}, sbz.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;
    int rem1, rem2, b0;
    logic [31:0] tag1, tag2;
    method_ena     = '0;
    method_ena_z   = '0;
    method_data    = '0;
    method_data_z  = '0;
    pipe_enq_rdy   = 1'b1;
    pipe_enq_rdy_z = 1'b1;

    // Reset state
    #1 nRST = 1'b1;
    #2;
    check("init_ena", pipe_enq_ena, 1'b0);
    check("init_data", pipe_enq_data, 32'd0);
    check("init_last", pipe_enq_last, 1'b0);
    check("init_ena_z", pipe_enq_ena_z, 1'b0);
    @(posedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b0;
    check("init_rdy", method_rdy, 3'b111);
    check("init_rdy_z", method_rdy_z, 3'b111);

    // 1: single ch0 message, args 1..4, header two cycles after enable
    @(posedge CLK); #1;
    set_args(0, 32'd1, 1'b0);
    method_ena = 3'b001;
    push_msg(0, 32'd1, 1'b0);
    @(posedge CLK); #1;
    method_ena = '0;
    check("t1_rdy_busy", method_rdy, 3'b110);
    check("t1_lat_t1", pipe_enq_ena, 1'b0);
    @(posedge CLK); #1;
    check("t1_lat_t2", pipe_enq_ena, 1'b1);
    check("t1_hdr", pipe_enq_data, 32'h0000_0005);
    check("t1_rdy_back", method_rdy, 3'b111);
    drain(1'b0, idle);

    // 2: all channels in one cycle, served in order without bubbles
    do_reset();
    @(posedge CLK); #1;
    set_args(0, 32'h100, 1'b0);
    set_args(1, 32'h200, 1'b0);
    set_args(2, 32'h300, 1'b0);
    method_ena = 3'b111;
    push_msg(0, 32'h100, 1'b0);
    push_msg(1, 32'h200, 1'b0);
    push_msg(2, 32'h300, 1'b0);
    @(posedge CLK); #1;
    method_ena = '0;
    check("t2_rdy_none", method_rdy, 3'b000);
    @(posedge CLK); #1;
    check("t2_rdy_ch0", method_rdy, 3'b001);
    drain(1'b0, idle);
    check("t2_no_bubble", 64'(idle), 64'd0);
    check("t2_rdy_all", method_rdy, 3'b111);

    // 3: ch1 refilled continuously while ch2 pending -> strict alternation
    do_reset();
    rem1 = 3;
    rem2 = 3;
    tag1 = 32'h1100;
    tag2 = 32'h2200;
    for (int n = 0; n < 400 && (rem1 > 0 || rem2 > 0); n++) begin
      @(posedge CLK); #1;
      method_ena = '0;
      if (rem1 > 0 && method_rdy[1]) begin
        set_args(1, tag1, 1'b0);
        method_ena[1] = 1'b1;
        push_msg(1, tag1, 1'b0);
        tag1 = tag1 + 32'h10;
        rem1--;
      end
      if (rem2 > 0 && method_rdy[2]) begin
        set_args(2, tag2, 1'b0);
        method_ena[2] = 1'b1;
        push_msg(2, tag2, 1'b0);
        tag2 = tag2 + 32'h10;
        rem2--;
      end
    end
    @(posedge CLK); #1;
    method_ena = '0;
    check("t3_all_sent", 64'(rem1 + rem2), 64'd0);
    drain(1'b0, idle);

    // 4: random back-pressure on a 2-word ch2 message
    do_reset();
    pipe_enq_rdy = 1'b0;
    @(posedge CLK); #1;
    set_args(2, 32'hABC0, 1'b0);
    method_ena = 3'b100;
    push_msg(2, 32'hABC0, 1'b0);
    b0 = beats;
    @(posedge CLK); #1;
    method_ena = '0;
    drain(1'b1, idle);
    repeat (4) @(posedge CLK);
    #1;
    check("t4_beat_count", 64'(beats - b0), 64'd3);

    // 5: zero-length method gives a lone header marked last
    @(posedge CLK); #1;
    method_ena_z = 3'b001;
    push_msg(0, 32'd0, 1'b1);
    b0 = beats_z;
    @(posedge CLK); #1;
    method_ena_z = '0;
    drain(1'b0, idle);
    repeat (3) @(posedge CLK);
    #1;
    check("t5_beat_count", 64'(beats_z - b0), 64'd1);
    check("t5_idle", pipe_enq_ena_z, 1'b0);

    // 6: reset during the second payload beat, then a fresh ch1 message
    do_reset();
    @(posedge CLK); #1;
    set_args(0, 32'h600, 1'b0);
    method_ena = 3'b001;
    push_msg(0, 32'h600, 1'b0);
    @(posedge CLK); #1;
    method_ena = '0;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLK); #1;
      if (pipe_enq_ena && pipe_enq_data == 32'h601) break;
    end
    check("t6_reach", pipe_enq_data, 32'h601);
    #1;
    nRST = 1'b1;
    sb.delete();
    #1;
    check("t6_rst_ena", pipe_enq_ena, 1'b0);
    check("t6_rst_data", pipe_enq_data, 32'd0);
    check("t6_rst_last", pipe_enq_last, 1'b0);
    @(posedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b0;
    check("t6_rdy", method_rdy, 3'b111);
    @(posedge CLK); #1;
    check("t6_quiet", pipe_enq_ena, 1'b0);
    set_args(1, 32'h700, 1'b0);
    method_ena = 3'b010;
    push_msg(1, 32'h700, 1'b0);
    @(posedge CLK); #1;
    method_ena = '0;
    drain(1'b0, idle);
    repeat (5) @(posedge CLK);
    #1;
    check("t6_idle_after", pipe_enq_ena, 1'b0);
    check("t6_rdy_final", method_rdy, 3'b111);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
